// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - register map, CONTROL bit positions and byte-lane merge helper
package nios_system_sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_CLOCK_HZ  = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_SECONDS   = 3'd6;
  localparam logic [2:0] ADDR_CONTROL   = 3'd7;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nios_system_sysid_ext_if.sv
// rtl/nios_system_sysid_ext_if.sv - Avalon-MM slave bus bundle for the sysid peripheral
interface nios_system_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_tick.sv
// rtl/nios_system_sysid_tick.sv - prescaler producing a once-per-second tick and seconds counter
module nios_system_sysid_tick #(
  parameter logic [31:0] CLOCK_HZ = 32'd50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] seconds,
  output logic        tick
);

  logic [31:0] prescaler_q, prescaler_d;
  logic [31:0] seconds_q, seconds_d;

  // A tick fires on the last prescaler count of each second, only while counting.
  always_comb begin
    tick = enable && (prescaler_q == CLOCK_HZ - 32'd1);
  end

  // Next-state: clear beats everything, then wrap-and-tick, then plain count.
  always_comb begin
    prescaler_d = prescaler_q;
    seconds_d   = seconds_q;
    if (clear) begin
      prescaler_d = '0;
      seconds_d   = '0;
    end else if (tick) begin
      prescaler_d = '0;
      seconds_d   = seconds_q + 32'd1;
    end else if (enable) begin
      prescaler_d = prescaler_q + 32'd1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler_q <= '0;
      seconds_q   <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      seconds_q   <= seconds_d;
    end
  end

  assign seconds = seconds_q;

endmodule

// File: rtl/nios_system_sysid_ext.sv
// rtl/nios_system_sysid_ext.sv - system ID, scratch, uptime and seconds peripheral (top)
module nios_system_sysid_ext
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] ID           = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h5041_44E5,
  parameter logic [31:0] CLOCK_HZ     = 32'd50_000_000,
  parameter int          UPTIME_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  nios_system_sysid_ext_if.slave  bus
);

  logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
  logic [31:0]             scratch_q, scratch_d;
  logic [31:0]             shadow_q, shadow_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    readdatavalid_q, readdatavalid_d;
  logic                    freeze_q, freeze_d;

  logic        wr_en;
  logic        clear;
  logic [63:0] uptime_ext;
  logic [31:0] seconds;
  logic        tick_unused;

  // A read in the same cycle wins over a write, so the write is simply dropped.
  always_comb begin
    wr_en      = bus.write && !bus.read;
    clear      = wr_en && (bus.address == ADDR_CONTROL) && bus.writedata[CTRL_CLEAR];
    uptime_ext = 64'(uptime_q);
  end

  // Register writes: scratch honours byte lanes, CONTROL keeps only the FREEZE level.
  always_comb begin
    scratch_d = scratch_q;
    freeze_d  = freeze_q;
    if (wr_en && bus.address == ADDR_SCRATCH) begin
      scratch_d = merge_bytes(scratch_q, bus.writedata, bus.byteenable);
    end
    if (wr_en && bus.address == ADDR_CONTROL) begin
      freeze_d = bus.writedata[CTRL_FREEZE];
    end
  end

  // Uptime: clear has priority over freeze and over the increment; wraps silently.
  always_comb begin
    uptime_d = uptime_q;
    if (clear) begin
      uptime_d = '0;
    end else if (!freeze_q) begin
      uptime_d = uptime_q + {{(UPTIME_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Reading UPTIME_LO snapshots the upper counter bits so UPTIME_HI is tear-free.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.read && bus.address == ADDR_UPTIME_LO) begin
      shadow_d = uptime_ext[63:32];
    end
  end

  // Read pipeline: one-cycle latency, data held between responses.
  always_comb begin
    readdatavalid_d = bus.read;
    readdata_d      = readdata_q;
    if (bus.read) begin
      case (bus.address)
        ADDR_ID:        readdata_d = ID;
        ADDR_TIMESTAMP: readdata_d = TIMESTAMP;
        ADDR_CLOCK_HZ:  readdata_d = CLOCK_HZ;
        ADDR_SCRATCH:   readdata_d = scratch_q;
        ADDR_UPTIME_LO: readdata_d = uptime_ext[31:0];
        ADDR_UPTIME_HI: readdata_d = shadow_q;
        ADDR_SECONDS:   readdata_d = seconds;
        ADDR_CONTROL:   readdata_d = {30'd0, freeze_q, 1'b0};
        default:        readdata_d = '0;
      endcase
    end
  end

  // State registers; everything clears on reset, dropping any pending response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q        <= '0;
      scratch_q       <= '0;
      shadow_q        <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      freeze_q        <= 1'b0;
    end else begin
      uptime_q        <= uptime_d;
      scratch_q       <= scratch_d;
      shadow_q        <= shadow_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      freeze_q        <= freeze_d;
    end
  end

  nios_system_sysid_tick #(
    .CLOCK_HZ (CLOCK_HZ)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .enable  (!freeze_q),
    .seconds (seconds),
    .tick    (tick_unused)
  );

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

endmodule
